// File: rtl/aoi_sweep_checker_pkg.sv
// Shared types and the AOI reference function for the exhaustive AOI cell sweep checker.
package aoi_sweep_checker_pkg;

   localparam int unsigned MAX_N = 16;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   // NOR of AND groups; group 0 occupies the MSBs of the active N-bit field.
   function automatic logic aoi_expected(input logic [MAX_N-1:0] vec,
                                         input int unsigned ngroups,
                                         input int unsigned group_w);
      logic        any_grp;
      logic        grp;
      int unsigned idx;
      any_grp = 1'b0;
      for (int unsigned g = 0; g < MAX_N; g++) begin
         if (g < ngroups) begin
            grp = 1'b1;
            for (int unsigned i = 0; i < MAX_N; i++) begin
               if (i < group_w) begin
                  idx = ngroups * group_w - 1 - g * group_w - i;
                  grp = grp & vec[4'(idx)];
               end
            end
            any_grp = any_grp | grp;
         end
      end
      return ~any_grp;
   endfunction

endpackage

// File: rtl/aoi_sweep_checker_ref_model.sv
// Combinational expected-value generator for the AOI cell under test.
module aoi_ref_model
   import aoi_sweep_checker_pkg::*;
#(
   parameter int unsigned NGROUPS = 3,
   parameter int unsigned GROUP_W = 2
) (
   input  logic [NGROUPS*GROUP_W-1:0] vec,
   output logic                       exp_zn_c
);

   always_comb begin
      exp_zn_c = aoi_expected(MAX_N'(vec), NGROUPS, GROUP_W);
   end

endmodule

// File: rtl/aoi_sweep_checker.sv
// Exhaustive stimulus sweep of an AOI cell: hold each vector SETTLE cycles, then compare dut_zn.
module aoi_sweep_checker
   import aoi_sweep_checker_pkg::*;
#(
   parameter int unsigned NGROUPS      = 3,
   parameter int unsigned GROUP_W      = 2,
   parameter int unsigned SETTLE       = 2,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         dut_zn,
   output logic [NGROUPS*GROUP_W-1:0]   stim,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [NGROUPS*GROUP_W:0]     err_count,
   output logic [NGROUPS*GROUP_W-1:0]   first_fail_vec,
   output logic                         first_fail_valid
);

   localparam int unsigned N  = NGROUPS * GROUP_W;
   localparam int unsigned EW = N + 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     stim_d;
   logic [EW-1:0]    err_d;
   logic [N-1:0]     ffv_d;
   logic             ffvalid_d;
   logic             pass_d;
   logic             busy_d;
   logic             done_d;
   logic             exp_zn;
   logic             mismatch;

   aoi_ref_model #(
      .NGROUPS (NGROUPS),
      .GROUP_W (GROUP_W)
   ) u_ref (
      .vec      (stim),
      .exp_zn_c (exp_zn)
   );

   assign mismatch = (dut_zn != exp_zn);

   // State and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         stim             <= '0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         pass             <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         stim             <= stim_d;
         err_count        <= err_d;
         first_fail_vec   <= ffv_d;
         first_fail_valid <= ffvalid_d;
         pass             <= pass_d;
         busy             <= busy_d;
         done             <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stim_d    = stim;
      err_d     = err_count;
      ffv_d     = first_fail_vec;
      ffvalid_d = first_fail_valid;
      pass_d    = pass;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SETTLE;
               stim_d    = '0;
               cnt_d     = '0;
               err_d     = '0;
               ffvalid_d = 1'b0;
               pass_d    = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE - 1)) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               err_d = err_count + EW'(1);
               if (!first_fail_valid) begin
                  ffv_d     = stim;
                  ffvalid_d = 1'b1;
               end
            end
            // The last vector never increments, so stim cannot wrap.
            if ((stim == {N{1'b1}}) || (STOP_ON_FAIL && mismatch)) begin
               state_d = ST_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = ST_SETTLE;
               stim_d  = stim + N'(1);
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

endmodule

// File: doc/aoi_sweep_checker.md
AOI_SWEEP_CHECKER -- requirements
Module: aoi_sweep_checker

Interface
REQ-001 SHALL have parameter NGROUPS, default 3: number of AND groups feeding the NOR.
REQ-002 SHALL have parameter GROUP_W, default 2: inputs per AND group; N = NGROUPS*GROUP_W, legal range 2..16.
REQ-003 SHALL have parameter SETTLE, default 2: stimulus-hold cycles before each sample, legal range 1..255.
REQ-004 SHALL have parameter STOP_ON_FAIL, default 0: when 1, the sweep ends at the first mismatch.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: sweep request, sampled only in IDLE.
REQ-008 SHALL have port dut_zn, input, 1: output of the cell under test.
REQ-009 SHALL have port stim, output, N: registered stimulus to the cell; bit N-1 = group 0 input 1 (A1), LSB = last group's last input.
REQ-010 SHALL have port busy, output, 1: high while in SETTLE or CHECK.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at sweep end.
REQ-012 SHALL have port pass, output, 1: high only if the last sweep completed with zero mismatches.
REQ-013 SHALL have port err_count, output, N+1: number of mismatching vectors in the current/last sweep.
REQ-014 SHALL have port first_fail_vec, output, N: first mismatching vector; valid only when first_fail_valid is high.
REQ-015 SHALL have port first_fail_valid, output, 1: a mismatch has been recorded this sweep.

Function
REQ-016 Expected value SHALL be exp = NOT(OR over g of AND of stim[N-1-g*GROUP_W -: GROUP_W]).
REQ-017 FSM SHALL have states IDLE, SETTLE, CHECK, DONE.
REQ-018 IDLE + start=1 SHALL go to SETTLE, with stim=0, settle counter=0, err_count=0, first_fail_valid=0, pass=0.
REQ-019 SETTLE SHALL increment the settle counter and go to CHECK when the counter reaches SETTLE-1; stim SHALL be held.
REQ-020 CHECK SHALL compare dut_zn with exp(stim); on mismatch it SHALL increment err_count and, if first_fail_valid=0, capture stim into first_fail_vec and set first_fail_valid.
REQ-021 CHECK SHALL go to DONE if stim = 2^N-1, or if STOP_ON_FAIL=1 and this check mismatched; otherwise it SHALL increment stim, clear the counter and go to SETTLE.
REQ-022 Each vector SHALL therefore occupy exactly SETTLE+1 cycles; a full sweep occupies 2^N*(SETTLE+1) cycles from the first SETTLE cycle to the last CHECK cycle.
REQ-023 DONE SHALL last one cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-024 pass, err_count and first_fail_* SHALL hold their values in IDLE until the next accepted start.
REQ-025 start in SETTLE, CHECK or DONE SHALL be ignored; start held high SHALL be accepted on the first IDLE cycle.
REQ-026 stim SHALL never wrap: the increment past 2^N-1 SHALL not occur.

Reset
REQ-027 rst=1 SHALL force IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, counter=0.
REQ-028 rst during a sweep SHALL abort it with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and a function computing the AOI expected value from (vector, NGROUPS, GROUP_W).
REQ-030 A sub-module aoi_ref_model (combinational expected-value generator) SHALL be instantiated once; everything else is flat.

Verification
REQ-031 Default parameters, correct AOI222 model on dut_zn: start -> done 192 cycles after the first SETTLE cycle, pass=1, err_count=0, first_fail_valid=0.
REQ-032 dut_zn tied to 0 -> err_count=27, first_fail_vec=0, pass=0.
REQ-033 STOP_ON_FAIL=1, model wrong only at vector 6'b110000 -> done after 49 vectors, err_count=1, first_fail_vec=48.
REQ-034 rst asserted at vector 10 -> next cycle all outputs at reset values, no done pulse; a restart then completes with pass=1.
REQ-035 start held high throughout -> exactly one sweep per IDLE entry, and a start during busy does not restart or alter the stim sequence.
REQ-036 NGROUPS=2, GROUP_W=3, SETTLE=1, correct AOI33 model -> 64 vectors in 128 cycles, pass=1.
